alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo.sv | 120 ++++++++++++
 tb/tb_alu_result_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Result FIFO behind a fixed-latency execute stage. Credit-based issue control keeps
// stored plus in-flight results within capacity; head is first-word fall-through.
module alu_result_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     issue_en,
    output logic                     credit_ok,
    input  logic                     res_valid,
    input  logic [DATA_WIDTH-1:0]    res_y,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] inflight_q, inflight_d;
    logic [1:0]      err_q, err_d;

    logic            full;
    logic            push;
    logic            pop;
    logic            res_match;
    logic [CntW:0]   credit_sum;

    assign full      = (count_q == CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign push      = res_valid & (~full | pop);
    // A result retires an in-flight op if one exists or is being launched right now.
    assign res_match = res_valid & ((inflight_q != '0) | issue_en);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        err_d      = err_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            inflight_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase

            unique case ({issue_en, res_match})
                2'b10: begin
                    if (inflight_q != CntW'(DEPTH)) begin
                        inflight_d = inflight_q + CntW'(1);
                    end
                end
                2'b01:   inflight_d = inflight_q - CntW'(1);
                default: inflight_d = inflight_q;
            endcase

            if (res_valid && full && !pop) begin
                err_d[0] = 1'b1;
            end
            if (res_valid && (inflight_q == '0) && !issue_en) begin
                err_d[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= 2'b00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Storage is deliberately not reset; out_data is only meaningful with out_valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= res_y;
        end
    end

    assign credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
    assign credit_ok  = (credit_sum < (CntW + 1)'(DEPTH));
    assign out_data   = mem[rd_ptr_q];
    assign count      = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: driver pushes expected words into a queue,
// a negedge monitor pops and compares every accepted head word.
module tb_alu_result_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          issue_en;
    logic          credit_ok;
    logic          res_valid;
    logic [DW-1:0] res_y;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [2:0]    count;
    logic [1:0]    err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q [$];

    alu_result_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .issue_en  (issue_en),
        .credit_ok (credit_ok),
        .res_valid (res_valid),
        .res_y     (res_y),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic iss, input logic rv, input logic [DW-1:0] y,
                         input logic rdy, input logic keep);
        issue_en  = iss;
        res_valid = rv;
        res_y     = y;
        out_ready = rdy;
        flush     = 1'b0;
        if (rv && keep) exp_q.push_back(y);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got %0h expected no word", out_data);
            end else begin
                check("pop_data", {32'h0, out_data}, {32'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc();
        cyc();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_count", count, 3'd0);
        check("reset_err", err, 2'b00);
        check("reset_credit", credit_ok, 1'b1);
        rst = 1'b0;
        cyc();

        // Basic stream, latency 2: results 5,7,9
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1); check("a_credit0", credit_ok, 1'b1); cyc();
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1); check("a_credit1", credit_ok, 1'b1); cyc();
        drive(1'b1, 1'b1, 32'd5, 1'b1, 1'b1); check("a_credit2", credit_ok, 1'b1); cyc();
        check("a_fwft_valid", out_valid, 1'b1);
        check("a_fwft_data", out_data, 32'd5);
        drive(1'b0, 1'b1, 32'd7, 1'b1, 1'b1); check("a_credit3", credit_ok, 1'b1); cyc();
        drive(1'b0, 1'b1, 32'd9, 1'b1, 1'b1); check("a_credit4", credit_ok, 1'b1); cyc();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1); check("a_credit5", credit_ok, 1'b1); cyc();
        check("a_err", err, 2'b00);
        check("a_count", count, 3'd0);

        // Fill to capacity with out_ready low
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
            cyc();
        end
        check("b_credit_after_4_issues", credit_ok, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'h11 * (i + 1), 1'b0, 1'b1);
            cyc();
        end
        check("b_count_full", count, 3'd4);
        check("b_credit_full", credit_ok, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("b_credit_during_pop", credit_ok, 1'b0);
        cyc();
        check("b_credit_after_pop", credit_ok, 1'b1);
        check("b_count_after_pop", count, 3'd3);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0); cyc();
        drive(1'b0, 1'b1, 32'h55, 1'b0, 1'b1); cyc();
        check("b_refill_count", count, 3'd4);

        // Full with simultaneous push and pop
        drive(1'b1, 1'b1, 32'h66, 1'b1, 1'b1); cyc();
        check("c_count", count, 3'd4);
        check("c_head", out_data, 32'h33);
        check("c_err", err, 2'b00);

        // Full, no pop: word dropped
        drive(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b0); cyc();
        check("d_count", count, 3'd4);
        check("d_err", err, 2'b01);
        check("d_head", out_data, 32'h33);

        // Flush with two stored and two in flight
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0); cyc();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0); cyc();
        check("e_count_two", count, 3'd2);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0); cyc();
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0); cyc();
        drive(1'b1, 1'b1, 32'h77, 1'b1, 1'b0);
        flush = 1'b1;
        exp_q.delete();
        cyc();
        check("e_count", count, 3'd0);
        check("e_out_valid", out_valid, 1'b0);
        check("e_credit", credit_ok, 1'b1);
        check("e_err_kept", err, 2'b01);
        // In-flight tracking must restart from zero
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
            cyc();
        end
        check("e_credit_after_3", credit_ok, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h81 + i, 1'b0, 1'b1);
            cyc();
        end
        check("e_count_three", count, 3'd3);
        check("e_err_no_new", err, 2'b01);

        // Asynchronous reset away from any clock edge
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("f_out_valid", out_valid, 1'b0);
        check("f_count", count, 3'd0);
        check("f_err", err, 2'b00);
        check("f_credit", credit_ok, 1'b1);
        cyc();
        rst = 1'b0;
        cyc();

        // Result with nothing in flight: stored, err[1] set
        drive(1'b0, 1'b1, 32'hAB, 1'b1, 1'b1); cyc();
        check("g_err", err, 2'b10);
        check("g_count", count, 3'd1);
        check("g_valid", out_valid, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0); cyc();
        check("g_count_drained", count, 3'd0);

        // Back-to-back throughput at latency 2
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, i >= 2, 32'h100 + i - 2, 1'b1, 1'b1);
            check("h_credit", credit_ok, 1'b1);
            cyc();
        end
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        check("h_queue_drained", exp_q.size(), 0);
        cyc();
        check("h_count", count, 3'd0);
        check("h_err", err, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
